axi_4_lite_mst: RTL

// - Synthesizable AXI4-Lite master engine: turns a simple command/response stream into single AXI4-Lite transactions.
// - Used by on-chip controllers and as a self-checking bus driver for axi_4_lite_slv.
// - Adds a per-transaction timeout, local alignment check and response backpressure.
// - One transaction in flight at a time.

---
 rtl/axi_4_lite_mst_pkg.sv | 26 ++
 rtl/axi_4_lite_mst_if.sv | 32 +++
 rtl/axi_4_lite_mst.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_4_lite_mst_pkg.sv
// Shared types and constants for the AXI4-Lite master engine.
package axi_4_lite_mst_pkg;

  localparam int C_AXI_ADDR_WIDTH = 32;
  localparam int C_AXI_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    MST_ST_IDLE    = 3'd0,
    MST_ST_WR      = 3'd1,
    MST_ST_WR_RESP = 3'd2,
    MST_ST_RD_ADDR = 3'd3,
    MST_ST_RD_DATA = 3'd4,
    MST_ST_RSP     = 3'd5
  } mst_state_e;

  // Timer only has to hold values up to cycles-1; keep at least one bit.
  function automatic int timer_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/axi_4_lite_mst_if.sv
// AXI4-Lite bus bundle with master/slave views.
interface axi_4_lite_mst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    AWVALID, AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    WVALID, WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID, BREADY;
  logic [1:0]              BRESP;
  logic                    ARVALID, ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    RVALID, RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite master: one command in, one AXI4-Lite transaction out, one
// response back. Adds a local alignment check and a recovery timeout.
module axi_4_lite_mst
  import axi_4_lite_mst_pkg::*;
#(
  parameter int ADDR_WIDTH     = C_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = C_AXI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic                    RSP_WRITE,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_TIMEOUT,
  axi_4_lite_mst_if.master        M_AXI
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(STRB_W);
  localparam int TW         = timer_width(TIMEOUT_CYCLES);

  mst_state_e              state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    busy, timed_out, abort, aw_ok, w_ok, misaligned;

  assign misaligned = (ALIGN_CHECK != 0) && (CMD_ADDR[ALIGN_BITS-1:0] != '0);

  // Next-state, timer and registered-output computation.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cmd_ready_d   = cmd_ready_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;
    busy      = (state_q == MST_ST_WR) || (state_q == MST_ST_WR_RESP) ||
                (state_q == MST_ST_RD_ADDR) || (state_q == MST_ST_RD_DATA);
    timed_out = busy && (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    // Saturating count so a disabled or very long timeout never wraps.
    if (busy && (timer_q != '1)) timer_d = timer_q + TW'(1);
    // A write channel is "done" once its VALID has dropped or it handshakes now.
    aw_ok = !awvalid_q || M_AXI.AWREADY;
    w_ok  = !wvalid_q  || M_AXI.WREADY;

    case (state_q)
      MST_ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          write_d     = CMD_WRITE;
          addr_d      = CMD_ADDR;
          wdata_d     = CMD_WDATA;
          wstrb_d     = CMD_WSTRB;
          timer_d     = '0;
          if (misaligned) begin
            // Rejected locally: no bus traffic at all.
            state_d       = MST_ST_RSP;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = CMD_WRITE;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
          end else if (CMD_WRITE) begin
            state_d   = MST_ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = MST_ST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      MST_ST_WR: begin
        if (awvalid_q && M_AXI.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q  && M_AXI.WREADY)  wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = MST_ST_WR_RESP;
          bready_d = 1'b1;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      MST_ST_WR_RESP: begin
        if (M_AXI.BVALID) begin
          state_d       = MST_ST_RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_resp_d    = M_AXI.BRESP;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      MST_ST_RD_ADDR: begin
        if (M_AXI.ARREADY) begin
          state_d   = MST_ST_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      MST_ST_RD_DATA: begin
        if (M_AXI.RVALID) begin
          state_d       = MST_ST_RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_resp_d    = M_AXI.RRESP;
          // Error responses never leak slave data to the requester.
          rsp_rdata_d   = (M_AXI.RRESP == RESP_OKAY || M_AXI.RRESP == RESP_EXOKAY) ?
                          M_AXI.RDATA : '0;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      MST_ST_RSP: begin
        if (RSP_READY) begin
          state_d     = MST_ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = MST_ST_IDLE;
    endcase

    // Recovery path: withdraw from the bus and report a local SLVERR.
    if (abort) begin
      state_d       = MST_ST_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_write_d   = write_q;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q       <= MST_ST_IDLE;
      timer_q       <= '0;
      cmd_ready_q   <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_ready_q   <= cmd_ready_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_WRITE     = rsp_write_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_TIMEOUT   = rsp_timeout_q;

  assign M_AXI.AWVALID = awvalid_q;
  assign M_AXI.AWADDR  = addr_q;
  assign M_AXI.AWPROT  = 3'b000;
  assign M_AXI.WVALID  = wvalid_q;
  assign M_AXI.WDATA   = wdata_q;
  assign M_AXI.WSTRB   = wstrb_q;
  assign M_AXI.BREADY  = bready_q;
  assign M_AXI.ARVALID = arvalid_q;
  assign M_AXI.ARADDR  = addr_q;
  assign M_AXI.ARPROT  = 3'b000;
  assign M_AXI.RREADY  = rready_q;

endmodule
